// File: rtl/rom_arbiter_if.sv
// Bus bundle for rom_arbiter: fetch port, data port, shared response data and the ROM pins.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface rom_arbiter_if #(
    parameter int MDW = 32,
    parameter int MAW = 32
);
    logic           if_req;
    logic [MAW-1:0] if_addr;
    logic           if_gnt;
    logic           if_rvalid;
    logic           if_err;

    logic           d_req;
    logic [MAW-1:0] d_addr;
    logic           d_gnt;
    logic           d_rvalid;
    logic           d_err;

    logic [MDW-1:0] rdata;

    logic           romcs_n;
    logic [MAW-1:0] romaddr;
    logic [MDW-1:0] romdout;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, romdout,
        output if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, rdata, romcs_n, romaddr
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, romdout,
        input  if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, rdata, romcs_n, romaddr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port ROM arbiter: the data port normally wins, the fetch port is forced through after
// STARVE_MAX consecutive data grants. One access per cycle, response one cycle after grant.
module rom_arbiter #(
    parameter int MDW        = 32,
    parameter int MAW        = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rom_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_sel_t;

    resp_sel_t      resp_sel, resp_sel_nxt;
    logic           resp_err, resp_err_nxt;
    logic [3:0]     starve_cnt, starve_cnt_nxt;

    logic           grant_if, grant_d, grant_any;
    logic [MAW-1:0] gnt_addr;
    logic           addr_ok;

    // Only the first 4 KiB of the address space is backed, and only word-aligned.
    function automatic logic addr_valid(input logic [MAW-1:0] a);
        return ((a >> 12) == '0) && (a[1:0] == 2'b00);
    endfunction

    // NOTE: every signal in an always_comb gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (rst_n) begin
            if (bus.d_req && !(bus.if_req && starve_cnt == STARVE_LIMIT))
                grant_d = 1'b1;
            else if (bus.if_req)
                grant_if = 1'b1;
        end
        grant_any = grant_if | grant_d;
        gnt_addr  = grant_if ? bus.if_addr : bus.d_addr;
        addr_ok   = addr_valid(gnt_addr);
    end

    assign bus.if_gnt  = grant_if;
    assign bus.d_gnt   = grant_d;
    assign bus.romcs_n = !(grant_any && addr_ok);
    assign bus.romaddr = (grant_any && addr_ok) ? gnt_addr : '0;

    always_comb begin
        resp_sel_nxt   = RESP_NONE;
        resp_err_nxt   = 1'b0;
        starve_cnt_nxt = starve_cnt;

        if (grant_if)
            resp_sel_nxt = RESP_IF;
        else if (grant_d)
            resp_sel_nxt = RESP_D;
        resp_err_nxt = grant_any && !addr_ok;

        // The counter only measures a fetch request that is actually waiting.
        if (!bus.if_req || grant_if)
            starve_cnt_nxt = '0;
        else if (grant_d && starve_cnt < STARVE_LIMIT)
            starve_cnt_nxt = starve_cnt + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sel   <= RESP_NONE;
            resp_err   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            resp_sel   <= resp_sel_nxt;
            resp_err   <= resp_err_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign bus.if_rvalid = (resp_sel == RESP_IF);
    assign bus.d_rvalid  = (resp_sel == RESP_D);
    assign bus.if_err    = (resp_sel == RESP_IF) && resp_err;
    assign bus.d_err     = (resp_sel == RESP_D) && resp_err;
    assign bus.rdata     = (resp_sel != RESP_NONE && !resp_err) ? bus.romdout : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed-vector bench for rom_arbiter: stimulus pushes expected responses into a
// scoreboard queue, a separate monitor pops and compares on every rvalid.
module tb_rom_arbiter;

    typedef enum int {P_NONE = 0, P_IF = 1, P_D = 2} port_t;

    typedef struct {
        port_t       port;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [31:0] rom_mem [0:1023];

    rom_arbiter_if #(.MDW(32), .MAW(32)) bus ();

    rom_arbiter #(.MDW(32), .MAW(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: one-cycle read latency when selected.
    always @(posedge clk) begin
        if (!bus.romcs_n) bus.romdout <= rom_mem[bus.romaddr[11:2]];
    end

    function automatic logic [31:0] rom_word(input int idx);
        if (idx == 4) return 32'hA5A5_0001;
        return 32'(32'h5A00_0000 + idx * 32'h0001_0101);
    endfunction

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[31:12] == 20'h0) && (a[1:0] == 2'b00);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's requests, check the combinational grant side, queue the response.
    task automatic apply(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input port_t exp_g, input string tag);
        logic [31:0] a;
        logic        ok;
        logic        cs_n;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_addr  = da;
        #1;
        a    = (exp_g == P_IF) ? ia : da;
        ok   = addr_ok(a);
        cs_n = !(exp_g != P_NONE && ok);
        check({tag, "_if_gnt"}, bus.if_gnt, exp_g == P_IF);
        check({tag, "_d_gnt"}, bus.d_gnt, exp_g == P_D);
        check({tag, "_romcs_n"}, bus.romcs_n, cs_n);
        check({tag, "_romaddr"}, bus.romaddr, cs_n ? 32'h0 : a);
        if (exp_g != P_NONE)
            sb.push_back('{exp_g, !ok, ok ? rom_word(int'(a[11:2])) : 32'h0, cyc + 1});
    endtask

    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input port_t exp_g, input string tag);
        @(negedge clk);
        apply(ir, ia, dr, da, exp_g, tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_if_gnt"}, bus.if_gnt, 0);
        check({tag, "_d_gnt"}, bus.d_gnt, 0);
        check({tag, "_if_rvalid"}, bus.if_rvalid, 0);
        check({tag, "_d_rvalid"}, bus.d_rvalid, 0);
        check({tag, "_if_err"}, bus.if_err, 0);
        check({tag, "_d_err"}, bus.d_err, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_romcs_n"}, bus.romcs_n, 1);
        check({tag, "_romaddr"}, bus.romaddr, 0);
        check({tag, "_resp_sel"}, dut.resp_sel, 0);
        check({tag, "_resp_err"}, dut.resp_err, 0);
        check({tag, "_starve"}, dut.starve_cnt, 0);
    endtask

    // Monitor: every response must match the head of the scoreboard, one cycle after grant.
    initial begin
        exp_t  e;
        port_t p;
        forever begin
            @(negedge clk);
            if (bus.if_rvalid || bus.d_rvalid) begin
                check("rsp_exclusive", bus.if_rvalid & bus.d_rvalid, 0);
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
                end else begin
                    e = sb.pop_front();
                    p = bus.if_rvalid ? P_IF : P_D;
                    check("rsp_port", p, e.port);
                    check("rsp_err", bus.if_rvalid ? bus.if_err : bus.d_err, e.err);
                    check("rsp_rdata", bus.rdata, e.data);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = rom_word(i);
        rst_n       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h20;

        // Requests held during reset must not be granted.
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");

        // Single fetch, granted on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 32'h10, 0, 32'h0, P_IF, "fetch1");
        cycle(0, 32'h0, 0, 32'h0, P_NONE, "idle0");

        // Lone data request and lone fetch of a different word.
        cycle(0, 32'h0, 1, 32'h24, P_D, "data1");
        cycle(1, 32'hFFC, 0, 32'h0, P_IF, "fetch_top");
        cycle(0, 32'h0, 0, 32'h0, P_NONE, "idle1");

        // Contention: d,d,d,d,if,d with starve_cnt 0,1,2,3,4,0.
        begin
            port_t    g_tab[6] = '{P_D, P_D, P_D, P_D, P_IF, P_D};
            int       s_tab[6] = '{0, 1, 2, 3, 4, 0};
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check($sformatf("cont%0d_starve", i), dut.starve_cnt, s_tab[i]);
                apply(1, 32'h80, 1, 32'(32'h100 + 4 * i), g_tab[i], $sformatf("cont%0d", i));
            end
        end
        cycle(0, 32'h0, 0, 32'h0, P_NONE, "idle2");

        // Out-of-range data accesses: above 4 KiB, then misaligned.
        cycle(0, 32'h0, 1, 32'h0000_1000, P_D, "oor_hi");
        cycle(0, 32'h0, 1, 32'h0000_0006, P_D, "oor_mis");
        cycle(1, 32'h8000_0000, 0, 32'h0, P_IF, "oor_if");
        cycle(0, 32'h0, 0, 32'h0, P_NONE, "idle3");

        // Streaming fetch, one access per cycle.
        for (int i = 0; i < 8; i++)
            cycle(1, 32'(4 * i), 0, 32'h0, P_IF, $sformatf("stream%0d", i));
        cycle(0, 32'h0, 0, 32'h0, P_NONE, "idle4");

        // Fetch request drops after losing one cycle to the data port.
        cycle(1, 32'h40, 1, 32'h44, P_D, "drop0");
        @(negedge clk);
        check("drop1_starve", dut.starve_cnt, 1);
        apply(0, 32'h0, 0, 32'h0, P_NONE, "drop1");
        @(negedge clk);
        check("drop2_starve", dut.starve_cnt, 0);
        apply(0, 32'h0, 0, 32'h0, P_NONE, "drop2");

        // Reset mid-operation: a data grant whose response must be discarded.
        cycle(0, 32'h0, 1, 32'h20, P_D, "rst_mid");
        void'(sb.pop_back());
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_async");
        @(negedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 32'h8, 0, 32'h0, P_IF, "post_rst");
        cycle(0, 32'h0, 0, 32'h0, P_NONE, "idle5");

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
